// File: rtl/seg7_scan.sv
// Multiplexed 4-digit common-anode seven-segment driver with anti-ghost guard slots.
// Define SEG7_BLINK_EN to blink the minutes or seconds pair during adjust mode.
module seg7_scan #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned BLINK_DIV   = 25000000
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [2:0] min1_i,
  input  logic [3:0] min2_i,
  input  logic [2:0] sec1_i,
  input  logic [3:0] sec2_i,
  input  logic       adj_i,
  input  logic       sel_i,
  output logic [6:0] seg_o,
  output logic [3:0] an_o,
  output logic       dp_o
);

  localparam int unsigned RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [RW-1:0] rcnt_q, rcnt_d;
  logic [1:0]    idx_q, idx_d;
  logic          rcnt_wrap;
  logic [6:0]    seg_d, seg_q;
  logic [3:0]    an_d, an_q;
  logic          dp_d, dp_q;
  logic [3:0]    digit;
  logic          digit_tens;
  logic          pair_blank;

  // Tens digits only go to 5; anything out of range shows a dash.
  function automatic logic [6:0] decode(input logic [3:0] v, input logic tens);
    logic [6:0] s;
    if ((tens && v > 4'd5) || v > 4'd9) begin
      s = 7'b0111111;
    end else begin
      unique case (v)
        4'd0:    s = 7'b1000000;
        4'd1:    s = 7'b1111001;
        4'd2:    s = 7'b0100100;
        4'd3:    s = 7'b0110000;
        4'd4:    s = 7'b0011001;
        4'd5:    s = 7'b0010010;
        4'd6:    s = 7'b0000010;
        4'd7:    s = 7'b1111000;
        4'd8:    s = 7'b0000000;
        default: s = 7'b0010000;
      endcase
    end
    return s;
  endfunction

  always_comb begin
    rcnt_wrap = (rcnt_q == RW'(REFRESH_DIV - 1));
    rcnt_d    = rcnt_wrap ? '0 : rcnt_q + 1'b1;
    idx_d     = rcnt_wrap ? idx_q + 2'd1 : idx_q;
  end

  always_comb begin
    digit      = sec2_i;
    digit_tens = 1'b0;
    unique case (idx_q)
      2'd0: begin digit = sec2_i;         digit_tens = 1'b0; end
      2'd1: begin digit = {1'b0, sec1_i}; digit_tens = 1'b1; end
      2'd2: begin digit = min2_i;         digit_tens = 1'b0; end
      default: begin digit = {1'b0, min1_i}; digit_tens = 1'b1; end
    endcase
  end

`ifdef SEG7_BLINK_EN
  localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          bph_q, bph_d;

  always_comb begin
    bcnt_d = '0;
    bph_d  = 1'b0;
    if (adj_i) begin
      if (bcnt_q == BW'(BLINK_DIV - 1)) begin
        bcnt_d = '0;
        bph_d  = ~bph_q;
      end else begin
        bcnt_d = bcnt_q + 1'b1;
        bph_d  = bph_q;
      end
    end
  end

  // sel=1 blanks the seconds pair (idx 0,1), sel=0 the minutes pair (idx 2,3).
  assign pair_blank = adj_i && bph_q && (sel_i ? ~idx_q[1] : idx_q[1]);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      bcnt_q <= '0;
      bph_q  <= 1'b0;
    end else begin
      bcnt_q <= bcnt_d;
      bph_q  <= bph_d;
    end
  end
`else
  logic unused_blink;
  assign unused_blink = ^{adj_i, sel_i, BLINK_DIV[0]};
  assign pair_blank   = 1'b0;
`endif

  always_comb begin
    an_d  = 4'b1111;
    seg_d = 7'b1111111;
    dp_d  = 1'b1;
    if (rcnt_q != '0 && !pair_blank) begin
      an_d        = 4'b1111;
      an_d[idx_q] = 1'b0;
      seg_d       = decode(digit, digit_tens);
      dp_d        = (idx_q != 2'd2);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rcnt_q <= '0;
      idx_q  <= 2'd0;
      an_q   <= 4'b1111;
      seg_q  <= 7'b1111111;
      dp_q   <= 1'b1;
    end else begin
      rcnt_q <= rcnt_d;
      idx_q  <= idx_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
      dp_q   <= dp_d;
    end
  end

  assign an_o  = an_q;
  assign seg_o = seg_q;
  assign dp_o  = dp_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Bench for seg7_scan: table-driven digit patterns, scan timing, reset and blink sequences.
module tb_seg7_scan;

  localparam int unsigned R = 4;
  localparam int unsigned B = 8;
`ifdef SEG7_BLINK_EN
  localparam bit BlinkEn = 1'b1;
`else
  localparam bit BlinkEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] min1 = '0, sec1 = '0;
  logic [3:0] min2 = '0, sec2 = '0;
  logic       adj = 1'b0, sel = 1'b0;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;

  always #5 clk = ~clk;

  seg7_scan #(.REFRESH_DIV(R), .BLINK_DIV(B)) dut (
    .clk_i(clk), .reset_i(reset), .min1_i(min1), .min2_i(min2), .sec1_i(sec1), .sec2_i(sec2),
    .adj_i(adj), .sel_i(sel), .seg_o(seg), .an_o(an), .dp_o(dp)
  );

  typedef struct {
    logic [2:0]      min1;
    logic [3:0]      min2;
    logic [2:0]      sec1;
    logic [3:0]      sec2;
    logic [3:0][6:0] seg;  // expected pattern per slot, index = slot
  } vec_t;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  vec_t            vecs[4];
  exp_t            sb[$];
  logic [3:0][6:0] tseg;
  int              k;
  int              checks = 0;
  int              errors = 0;

  // Push the expectation for the coming edge, clock it, then check 1 time unit later.
  task automatic step();
    exp_t e, got;
    int kk, slot, pos;
    kk   = k + 1;
    slot = ((kk - 1) / R) % 4;
    pos  = (kk - 1) % R;
    e.an = 4'b1111; e.seg = 7'b1111111; e.dp = 1'b1;
    if (!reset && pos != 0 &&
        !(BlinkEn && adj && (((kk - 1) / B) % 2 == 1) && (sel ? slot < 2 : slot >= 2))) begin
      e.an       = 4'b1111;
      e.an[slot] = 1'b0;
      e.seg      = tseg[slot];
      e.dp       = (slot != 2);
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    checks++;
    if (an !== got.an || seg !== got.seg || dp !== got.dp) begin
      errors++;
      $display("FAIL scan k=%0d: got an=%b seg=%b dp=%b, want an=%b seg=%b dp=%b",
               kk, an, seg, dp, got.an, got.seg, got.dp);
    end
    k = reset ? 0 : kk;
  endtask

  task automatic load(input int i);
    min1 = vecs[i].min1; min2 = vecs[i].min2;
    sec1 = vecs[i].sec1; sec2 = vecs[i].sec2;
    tseg = vecs[i].seg;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    vecs[0] = '{min1: 3'd1, min2: 4'd2, sec1: 3'd3, sec2: 4'd4,
                seg: {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}};
    vecs[1] = '{min1: 3'd7, min2: 4'd0, sec1: 3'd5, sec2: 4'd12,
                seg: {7'b0111111, 7'b1000000, 7'b0010010, 7'b0111111}};
    vecs[2] = '{min1: 3'd5, min2: 4'd9, sec1: 3'd0, sec2: 4'd8,
                seg: {7'b0010010, 7'b0010000, 7'b1000000, 7'b0000000}};
    vecs[3] = '{min1: 3'd3, min2: 4'd6, sec1: 3'd6, sec2: 4'd7,
                seg: {7'b0110000, 7'b0000010, 7'b0111111, 7'b1111000}};
    k = 0;
    load(0);
    do_reset();
    do_reset();

    // Two full frames per digit pattern, starting from a fresh reset.
    for (int i = 0; i < 4; i++) begin
      load(i);
      do_reset();
      for (int c = 0; c < 8 * R; c++) step();
    end

    // Reset in the middle of slot idx2, then the scan restarts at idx0.
    load(0);
    do_reset();
    for (int c = 0; c < 2 * R + 2; c++) step();
    do_reset();
    for (int c = 0; c < R + 2; c++) step();

    // sec2 change mid-slot idx0 shows up on the next edge.
    load(0);
    sec2 = 4'd3;
    tseg[0] = 7'b0110000;
    do_reset();
    step();
    step();
    sec2 = 4'd4;
    tseg[0] = 7'b0011001;
    step();
    step();

    // Adjust seconds pair: blank windows of B cycles (blink build), then adj drop.
    load(0);
    adj = 1'b1;
    sel = 1'b1;
    do_reset();
    for (int c = 0; c < 5 * B; c++) step();
    adj = 1'b0;
    for (int c = 0; c < 2 * R; c++) step();

    // Adjust minutes pair, held long enough for several blink phases.
    adj = 1'b1;
    sel = 1'b0;
    do_reset();
    for (int c = 0; c < 100; c++) step();
    adj = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
